oam_dma: RTL and testbench
==========================

# oam_dma

Sprite DMA bus master for the NES core. On a CPU write to $4014 it halts the CPU, takes the system bus, and copies the 256-byte CPU page named by the written value into the PPU OAM data port ($2004) as alternating read/write bus cycles. It sits beside the CPU on the shared address/data bus. It is the initiator side of the same memory interface the CPU uses, and the memory model and RAM answer it exactly as they answer the CPU.

## Interface
- TRIG_ADDR, 16'h4014, CPU write address that starts a transfer
- OAM_ADDR, 16'h2004, destination address driven on every write cycle
- clk_ph1  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  16  CPU address bus, snooped for TRIG_ADDR
- cpu_dout  in  8  CPU write data; supplies the source page number
- cpu_rw  in  1  CPU direction; 1 = read, 0 = write
- cpu_halt  out  1  1 = CPU must stall and release the bus
- dma_active  out  1  1 = DMA owns the bus; bus mux selects dma_* signals
- dma_addr  out  16  DMA address bus
- dma_rw  out  1  DMA direction; 1 = read, 0 = write
- dma_dout  out  8  DMA write data
- dma_din  in  8  read data returned by memory (the shared Data_bus)

## Operation
- The parity flop `par` resets to 0 and toggles every cycle, free-running.
- The trigger is `cpu_addr==TRIG_ADDR && cpu_rw==0` sampled while in IDLE. On the trigger, latch `page<=cpu_dout` and `idx<=0`.
- States:
  - IDLE: waits for the trigger, then goes to HALT.
  - HALT: one dummy cycle with no bus access. Next state is READ if `par==1` during HALT, else ALIGN.
  - ALIGN: one dummy cycle, then READ.
  - READ: `dma_addr={page,idx}`, `dma_rw=1`. Latch `dma_din` into `buf` at the cycle end. Next state is WRITE.
  - WRITE: `dma_addr=OAM_ADDR`, `dma_rw=0`, `dma_dout=buf`. Next state is READ with `idx+1` if `idx!=8'hFF`, else IDLE.
- `idx` is 8 bits and never carries into `page`. The source range is exactly {page,00}..{page,FF}.
- `cpu_halt` and `dma_active` are 1 in HALT, ALIGN, READ and WRITE, and 0 in IDLE.
- In IDLE and dummy states: `dma_addr=0`, `dma_rw=1`, `dma_dout=0`.
- A TRIG_ADDR write while not in IDLE is ignored. No retrigger or queueing.
- A CPU read of TRIG_ADDR, or a write to any other address, has no effect.
- Reset at any point: next state is IDLE and all outputs return to their reset values. A partial transfer is abandoned and not resumed.

## Timing
- Reset values: `cpu_halt=0`, `dma_active=0`, `dma_addr=16'h0000`, `dma_rw=1`, `dma_dout=8'h00`, `par=0`, `idx=0`, `page=0`, `buf=0`.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- Trigger cycle T, sampled at the rising edge ending T:
  - HALT is at T+1.
  - If `par` at T was 0, READ starts at T+2. If `par` at T was 1, ALIGN is at T+2 and READ starts at T+3.
- Halt length is 513 cycles (even trigger parity) or 514 (odd). READ always falls on `par==0` cycles and WRITE on `par==1` cycles.
- The final WRITE of {page,FF} is the last cycle with `cpu_halt=1`. The CPU resumes on the following cycle.
- `buf` captures `dma_din` at the READ cycle end. Memory must present data within the same cycle, as for CPU reads.

## Test plan
- Even-parity trigger:
  - Stimulus: write 8'h02 to $4014 with `par=0`; memory returns low address byte XOR 8'hA5.
  - Required: halt for exactly 513 cycles; bus sequence 0200(r), 2004(w, A5), 0201(r), 2004(w, A4) … 02FF(r), 2004(w, 5A); `cpu_halt` falls after the 256th write.
- Odd-parity trigger:
  - Stimulus: same as above with `par=1`.
  - Required: one ALIGN cycle; halt lasts 514 cycles; first READ at T+3; every READ has `par=0`.
- Non-triggers:
  - Stimulus: CPU read of $4014, then write of 8'h03 to $4015.
  - Required: `cpu_halt` stays 0 and `dma_addr` stays 0000.
- Page wrap:
  - Stimulus: trigger with 8'hFF.
  - Required: reads run FF00..FFFF; no access to 0000 or 0100; 256 writes total.
- Reset mid-transfer:
  - Stimulus: assert `rst` for one cycle during the READ of idx 8'h64, then retrigger with 8'h07.
  - Required: the cycle after reset shows all reset values; the new transfer starts at 0700 with idx=0.
- Retrigger ignored:
  - Stimulus: force `cpu_addr=$4014`, `cpu_rw=0` during an active transfer.
  - Required: `page` is unchanged and the transfer completes with the original count.

Source files
------------

// File: rtl/oam_dma.sv
// Sprite DMA bus master: on a CPU write to TRIG_ADDR it halts the CPU and copies
// the 256-byte page {page,00}..{page,FF} to OAM_ADDR as alternating read/write cycles.
module oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rw,
  output logic        cpu_halt,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_rw,
  output logic [7:0]  dma_dout,
  input  logic [7:0]  dma_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic        par_q;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  buf_q, buf_d;
  logic        trig;

  assign trig = (cpu_addr == TRIG_ADDR) && !cpu_rw;

  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      state_q <= S_IDLE;
      par_q   <= 1'b0;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      buf_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      par_q   <= ~par_q;
      page_q  <= page_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_HALT;
          page_d  = cpu_dout;
          idx_d   = 8'h00;
        end
      end
      // Reads must land on even parity; an odd HALT cycle leads straight to READ.
      S_HALT:  state_d = par_q ? S_READ : S_ALIGN;
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        buf_d   = dma_din;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q != 8'hFF) begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs decode only registered state, so no input reaches an output combinationally.
  always_comb begin
    cpu_halt   = 1'b0;
    dma_active = 1'b0;
    dma_addr   = 16'h0000;
    dma_rw     = 1'b1;
    dma_dout   = 8'h00;
    case (state_q)
      S_HALT, S_ALIGN: begin
        cpu_halt   = 1'b1;
        dma_active = 1'b1;
      end
      S_READ: begin
        cpu_halt   = 1'b1;
        dma_active = 1'b1;
        dma_addr   = {page_q, idx_q};
      end
      S_WRITE: begin
        cpu_halt   = 1'b1;
        dma_active = 1'b1;
        dma_addr   = OAM_ADDR;
        dma_rw     = 1'b0;
        dma_dout   = buf_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: even/odd parity transfers, non-triggers, page FF,
// mid-transfer reset and ignored retrigger, against a memory returning addr[7:0]^A5.
module tb_oam_dma;

  logic        clk_ph1 = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw;
  logic        cpu_halt;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_dout;
  logic [7:0]  dma_din;
  logic        tb_par;

  int n_chk  = 0;
  int n_fail = 0;

  oam_dma dut (
    .clk_ph1   (clk_ph1),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_rw    (cpu_rw),
    .cpu_halt  (cpu_halt),
    .dma_active(dma_active),
    .dma_addr  (dma_addr),
    .dma_rw    (dma_rw),
    .dma_dout  (dma_dout),
    .dma_din   (dma_din)
  );

  always #5 clk_ph1 = ~clk_ph1;

  // Memory answers within the cycle: low address byte XOR A5.
  assign dma_din = dma_addr[7:0] ^ 8'hA5;

  // Reference parity: reset to 0, toggles every cycle.
  always_ff @(posedge clk_ph1) begin
    if (rst) tb_par <= 1'b0;
    else     tb_par <= ~tb_par;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_halt"},   cpu_halt,   1'b0);
    check({tag, "_active"}, dma_active, 1'b0);
    check({tag, "_addr"},   dma_addr,   16'h0000);
    check({tag, "_rw"},     dma_rw,     1'b1);
    check({tag, "_dout"},   dma_dout,   8'h00);
  endtask

  // Issues the trigger in a cycle with the requested parity; returns in cycle T+1.
  task automatic trigger(input logic [7:0] pg, input logic want_par);
    int guard = 0;
    while (tb_par !== want_par && guard < 4) begin
      tick();
      guard++;
    end
    cpu_addr = 16'h4014;
    cpu_rw   = 1'b0;
    cpu_dout = pg;
    tick();
    cpu_addr = 16'h0000;
    cpu_rw   = 1'b1;
    cpu_dout = 8'h00;
    check("halt_T1",   cpu_halt, 1'b1);
    check("addr_T1",   dma_addr, 16'h0000);
    check("rw_T1",     dma_rw,   1'b1);
  endtask

  // Walks the transfer from cycle T+1 comparing every bus cycle.
  task automatic run_transfer(input logic [7:0] pg, input int exp_len, input bit retrig);
    int first_read = exp_len - 512;
    int seq_err = 0, par_err = 0, writes = 0, out_pg = 0, halt_cnt = 0;
    logic [15:0] ea;
    logic        erw;
    logic [7:0]  ed;
    for (int k = 0; k < exp_len; k++) begin
      if (k < first_read) begin
        ea = 16'h0000; erw = 1'b1; ed = 8'h00;
      end else if (((k - first_read) % 2) == 0) begin
        ea = {pg, 8'((k - first_read) / 2)}; erw = 1'b1; ed = 8'h00;
      end else begin
        ea = 16'h2004; erw = 1'b0; ed = 8'((k - first_read) / 2) ^ 8'hA5;
      end
      if (cpu_halt === 1'b1) halt_cnt++;
      if (dma_active !== 1'b1 || dma_addr !== ea || dma_rw !== erw || dma_dout !== ed)
        seq_err++;
      if (k >= first_read && dma_rw === 1'b1 && tb_par !== 1'b0) par_err++;
      if (dma_rw === 1'b0) writes++;
      if (k >= first_read && dma_rw === 1'b1 && dma_addr[15:8] !== pg) out_pg++;
      if (k == first_read - 1) check("pre_read_addr", dma_addr, 16'h0000);
      if (k == first_read)     check("first_read",    dma_addr, {pg, 8'h00});
      if (k == first_read + 1) check("first_wdata",   dma_dout, 8'hA5);
      if (k == exp_len - 1)    check("last_wdata",    dma_dout, 8'h5A);
      if (retrig && k == 100) begin
        cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_dout = 8'h55;
      end else if (retrig && k == 101) begin
        cpu_addr = 16'h0000; cpu_rw = 1'b1; cpu_dout = 8'h00;
      end
      tick();
    end
    check("seq_err",     seq_err,  0);
    check("read_parity", par_err,  0);
    check("writes",      writes,   256);
    check("out_of_page", out_pg,   0);
    check("halt_len",    halt_cnt, exp_len);
    check_idle_outputs("after");
  endtask

  initial begin
    rst = 1'b1; cpu_addr = 16'h0000; cpu_rw = 1'b1; cpu_dout = 8'h00;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Even parity, page 02
    trigger(8'h02, 1'b0);
    run_transfer(8'h02, 513, 1'b0);

    // Odd parity, page 02
    trigger(8'h02, 1'b1);
    check("align_active", dma_active, 1'b1);
    run_transfer(8'h02, 514, 1'b0);

    // Non-triggers: CPU read of 4014, write to 4015
    cpu_addr = 16'h4014; cpu_rw = 1'b1; cpu_dout = 8'h05;
    tick(); tick();
    check("nt_read_halt", cpu_halt, 1'b0);
    check("nt_read_addr", dma_addr, 16'h0000);
    cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_dout = 8'h03;
    tick(); tick();
    check("nt_write_halt", cpu_halt, 1'b0);
    check("nt_write_addr", dma_addr, 16'h0000);
    cpu_addr = 16'h0000; cpu_rw = 1'b1; cpu_dout = 8'h00;
    tick();

    // Page FF
    trigger(8'hFF, 1'b0);
    run_transfer(8'hFF, 513, 1'b0);

    // Reset during READ of idx 64, then retrigger with page 07
    trigger(8'h10, 1'b0);
    for (int k = 0; k < 201; k++) tick();
    check("mid_read_addr", dma_addr, 16'h1064);
    check("mid_read_rw",   dma_rw,   1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("mid_rst");
    tick();
    check("post_rst_idle", cpu_halt, 1'b0);
    trigger(8'h07, 1'b0);
    run_transfer(8'h07, 513, 1'b0);

    // Retrigger during an active transfer is ignored
    trigger(8'h21, 1'b1);
    run_transfer(8'h21, 514, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
